// File: rtl/lcd_ctrl_p.sv
// lcd_ctrl_p: image window processor for a COLS x ROWS pixel frame.
//
// After reset the frame is fetched from an external image ROM into a local
// register image. Commands then move a 2x2 operation window or rewrite its
// four pixels. A write command streams the whole image to the result buffer,
// after which the block parks in DONE until the next reset.
//
// Ports
//   clk        clock, all state changes on the rising edge
//   reset      asynchronous active-low reset
//   cmd        command code (0 write, 1..4 move, 5..11 window ops, 12..15 nop)
//   cmd_valid  command qualifier, sampled only while idle
//   IROM_Q     ROM read data, valid one cycle after IROM_A
//   IROM_EN    ROM enable, active-low
//   IROM_A     ROM address
//   IRB_RW     result buffer strobe: 0 = write, 1 = idle
//   IRB_A      result buffer address
//   IRB_D      result buffer write data
//   busy       high while commands are not accepted
//   done       high once the writeback has completed
module lcd_ctrl_p #(
  parameter int DW = 8,
  parameter int XW = 3,
  parameter int YW = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           cmd,
  input  logic                 cmd_valid,
  input  logic [DW-1:0]        IROM_Q,
  output logic                 IROM_EN,
  output logic [XW+YW-1:0]     IROM_A,
  output logic                 IRB_RW,
  output logic [XW+YW-1:0]     IRB_A,
  output logic [DW-1:0]        IRB_D,
  output logic                 busy,
  output logic                 done
);

  localparam int AW = XW + YW;
  localparam int N  = 1 << AW;
  localparam logic [XW-1:0] X_MID = XW'(1 << (XW - 1));
  localparam logic [YW-1:0] Y_MID = YW'(1 << (YW - 1));
  localparam logic [XW-1:0] X_ONE = XW'(1);
  localparam logic [YW-1:0] Y_ONE = YW'(1);

  typedef enum logic [2:0] {
    S_LOAD  = 3'd0,
    S_IDLE  = 3'd1,
    S_EXEC  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          state_q, state_d;

  logic            load_go_q;     // first edge after reset release starts the fetch
  logic            fetch_done_q;  // all addresses presented, last datum in flight
  logic [AW-1:0]   rom_a_q;
  logic            pend_q;        // IROM_Q carries data for pend_a_q this cycle
  logic [AW-1:0]   pend_a_q;
  logic [AW-1:0]   wr_a_q;
  logic [XW-1:0]   x_q;
  logic [YW-1:0]   y_q;
  logic [3:0]      cmd_q;

  logic [DW-1:0]   img_q [N];

  // Window addresses: address = Y*COLS + X, i.e. {Y, X}.
  logic [XW-1:0]   xm1;
  logic [YW-1:0]   ym1;
  logic [AW-1:0]   a1, a2, a3, a4;
  logic [DW-1:0]   p1, p2, p3, p4;
  logic [DW-1:0]   n1, n2, n3, n4;
  logic [DW+1:0]   sum;
  logic [DW-1:0]   mx12, mx34, mn12, mn34, mx, mn;
  logic            win_we;
  logic            ld_we;

  assign xm1 = x_q - X_ONE;
  assign ym1 = y_q - Y_ONE;
  assign a1  = {ym1, xm1};
  assign a2  = {ym1, x_q};
  assign a3  = {y_q, xm1};
  assign a4  = {y_q, x_q};

  assign p1 = img_q[a1];
  assign p2 = img_q[a2];
  assign p3 = img_q[a3];
  assign p4 = img_q[a4];

  // Sum is two bits wider than a pixel so four full-scale values cannot wrap.
  assign sum  = {2'b00, p1} + {2'b00, p2} + {2'b00, p3} + {2'b00, p4};
  assign mx12 = (p1 > p2) ? p1 : p2;
  assign mx34 = (p3 > p4) ? p3 : p4;
  assign mx   = (mx12 > mx34) ? mx12 : mx34;
  assign mn12 = (p1 < p2) ? p1 : p2;
  assign mn34 = (p3 < p4) ? p3 : p4;
  assign mn   = (mn12 < mn34) ? mn12 : mn34;

  assign win_we = (state_q == S_EXEC) && (cmd_q inside {[4'd5:4'd11]});
  assign ld_we  = (state_q == S_LOAD) && pend_q;

  // New window values; all derived from the pre-update pixels.
  always_comb begin
    n1 = p1;
    n2 = p2;
    n3 = p3;
    n4 = p4;
    case (cmd_q)
      4'd5: begin
        n1 = sum[DW+1:2];
        n2 = sum[DW+1:2];
        n3 = sum[DW+1:2];
        n4 = sum[DW+1:2];
      end
      4'd6: begin
        n1 = p2; n2 = p1; n3 = p4; n4 = p3;
      end
      4'd7: begin
        n1 = p3; n2 = p4; n3 = p1; n4 = p2;
      end
      4'd8: begin
        n1 = mx; n2 = mx; n3 = mx; n4 = mx;
      end
      4'd9: begin
        n1 = mn; n2 = mn; n3 = mn; n4 = mn;
      end
      4'd10: begin
        n1 = p3; n2 = p1; n3 = p4; n4 = p2;
      end
      4'd11: begin
        n1 = p2; n2 = p4; n3 = p1; n4 = p3;
      end
      default: ;
    endcase
  end

  // Image storage has no reset; its contents are undefined until loaded.
  always_ff @(posedge clk) begin
    if (ld_we) begin
      img_q[pend_a_q] <= IROM_Q;
    end
    if (win_we) begin
      img_q[a1] <= n1;
      img_q[a2] <= n2;
      img_q[a3] <= n3;
      img_q[a4] <= n4;
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LOAD:  if (pend_q && (pend_a_q == AW'(N - 1))) state_d = S_IDLE;
      S_IDLE:  if (cmd_valid) state_d = (cmd == 4'd0) ? S_WRITE : S_EXEC;
      S_EXEC:  state_d = S_IDLE;
      S_WRITE: if (wr_a_q == AW'(N - 1)) state_d = S_DONE;
      S_DONE:  state_d = S_DONE;
      default: state_d = S_LOAD;
    endcase
  end

  // Counters, operation point and latched command
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      load_go_q    <= 1'b0;
      fetch_done_q <= 1'b0;
      rom_a_q      <= '0;
      pend_q       <= 1'b0;
      pend_a_q     <= '0;
      wr_a_q       <= '0;
      x_q          <= X_MID;
      y_q          <= Y_MID;
      cmd_q        <= 4'd0;
    end else begin
      case (state_q)
        S_LOAD: begin
          if (!load_go_q) begin
            load_go_q <= 1'b1;
            rom_a_q   <= '0;
          end else begin
            // Data for the address presented now appears on IROM_Q next cycle.
            pend_q   <= !fetch_done_q;
            pend_a_q <= rom_a_q;
            if (!fetch_done_q) begin
              if (rom_a_q == AW'(N - 1)) begin
                fetch_done_q <= 1'b1;
              end else begin
                rom_a_q <= rom_a_q + AW'(1);
              end
            end
          end
          if (state_d == S_IDLE) begin
            pend_q <= 1'b0;
            x_q    <= X_MID;
            y_q    <= Y_MID;
          end
        end
        S_IDLE: begin
          if (cmd_valid) begin
            cmd_q  <= cmd;
            wr_a_q <= '0;
          end
        end
        S_EXEC: begin
          case (cmd_q)
            4'd1: if (y_q != Y_ONE) y_q <= y_q - Y_ONE;
            4'd2: if (y_q != '1)    y_q <= y_q + Y_ONE;
            4'd3: if (x_q != X_ONE) x_q <= x_q - X_ONE;
            4'd4: if (x_q != '1)    x_q <= x_q + X_ONE;
            default: ;
          endcase
        end
        S_WRITE: begin
          if (wr_a_q != AW'(N - 1)) wr_a_q <= wr_a_q + AW'(1);
        end
        default: ;
      endcase
    end
  end

  // Output logic
  always_comb begin
    busy    = 1'b1;
    done    = 1'b0;
    IRB_RW  = 1'b1;
    IRB_D   = '0;
    IROM_EN = 1'b1;
    case (state_q)
      S_LOAD: begin
        IROM_EN = !(load_go_q && !fetch_done_q);
      end
      S_IDLE: begin
        busy = 1'b0;
      end
      S_WRITE: begin
        IRB_RW = 1'b0;
        IRB_D  = img_q[wr_a_q];
      end
      S_DONE: begin
        busy = 1'b0;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  assign IROM_A = rom_a_q;
  assign IRB_A  = wr_a_q;

endmodule

// File: doc/lcd_ctrl_p.md
LCD_CTRL_P -- requirements
Module: lcd_ctrl_p

Interface
REQ-001 Parameter DW, default 8, pixel data width in bits.
REQ-002 Parameter XW, default 3, log2 of image columns (COLS=2^XW).
REQ-003 Parameter YW, default 3, log2 of image rows (ROWS=2^YW); N=COLS*ROWS pixels, AW=XW+YW.
REQ-004 Port clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port reset  input  1  asynchronous, active-low reset.
REQ-006 Port cmd  input  4  command code.
REQ-007 Port cmd_valid  input  1  command qualifier.
REQ-008 Port IROM_Q  input  DW  image ROM read data, valid one cycle after IROM_A.
REQ-009 Port IROM_EN  output  1  ROM enable, active-low.
REQ-010 Port IROM_A  output  AW  ROM address.
REQ-011 Port IRB_RW  output  1  result buffer strobe: 0=write, 1=idle/read.
REQ-012 Port IRB_A  output  AW  result buffer address.
REQ-013 Port IRB_D  output  DW  result buffer write data.
REQ-014 Port busy  output  1  high = commands not accepted.
REQ-015 Port done  output  1  high = writeback complete.

Function
REQ-016 States: LOAD, IDLE, EXEC, WRITE, DONE; LOAD is the state entered out of reset.
REQ-017 LOAD: IROM_EN=0; IROM_A steps 0..N-1, one per cycle; IROM_Q captured into img[A] on the edge after A presented; after img[N-1] is captured, go to IDLE (busy high for N+1 cycles).
REQ-018 Operation point (X,Y) set to (COLS/2, ROWS/2) on LOAD exit; window = p1=(X-1,Y-1), p2=(X,Y-1), p3=(X-1,Y), p4=(X,Y); address = Y*COLS+X.
REQ-019 IDLE: busy=0; command accepted on rising edge with cmd_valid=1; cmd_valid ignored in every other state.
REQ-020 cmd 0 (write): go to WRITE; all other codes: go to EXEC, perform operation at that edge's accepted code, busy=1 for exactly one cycle, return to IDLE.
REQ-021 cmd 1/2/3/4 = up/down/left/right: Y-1/Y+1/X-1/X+1, saturating to X in [1,COLS-1], Y in [1,ROWS-1]; at bound, no change.
REQ-022 cmd 5 average: all four pixels = floor(sum/4), sum computed at DW+2 bits (no overflow).
REQ-023 cmd 6 mirror X: swap p1<->p2, p3<->p4. cmd 7 mirror Y: swap p1<->p3, p2<->p4.
REQ-024 cmd 8 max / cmd 9 min: all four pixels = max / min of the four (unsigned).
REQ-025 cmd 10 rotate CW: new p1=p3, p2=p1, p4=p2, p3=p4. cmd 11 rotate CCW: inverse of CW.
REQ-026 cmd 12..15: no operation, still consume the EXEC cycle.
REQ-027 All window operations read pre-update values (simultaneous assignment of four pixels).
REQ-028 WRITE: busy=1, IRB_RW=0, IRB_A steps 0..N-1 one per cycle, IRB_D=img[IRB_A] same cycle; after A=N-1, go to DONE.
REQ-029 DONE: terminal until reset; busy=0, done=1, IRB_RW=1, IROM_EN=1.
REQ-030 IROM_EN=1 outside LOAD; IRB_RW=1 outside WRITE; done=0 outside DONE.

Reset
REQ-031 Reset low asynchronously forces LOAD with counters 0, busy=1, done=0, IROM_EN=1, IROM_A=0, IRB_RW=1, IRB_A=0, IRB_D=0; img contents undefined.
REQ-032 Reset asserted mid-LOAD, EXEC or WRITE aborts the operation; first rising edge after release begins LOAD at address 0 with IROM_EN=0.

Verification (defaults DW=8, XW=YW=3, ROM pixel i = i unless stated)
REQ-033 Reset release -> IROM_EN=0, IROM_A=0..63 on consecutive cycles, busy=1 for 65 cycles then 0; write cmd -> IRB_A=0..63 with IRB_D=0..63, IRB_RW=0, then done=1, busy=0.
REQ-034 cmd 5 at (4,4) -> pixels 27,28,35,36 read back 31,31,31,31; ROM all 255, cmd 5 -> window reads 255 (no overflow).
REQ-035 Six cmd 1 then six cmd 3 -> point (1,1); cmd 6 -> addresses 0,1,8,9 read back 1,0,9,8; pixel 0 unchanged by further cmd 1/3.
REQ-036 cmd 10 at (4,4) -> 27,28,35,36 read back 35,27,36,28; cmd 11 follows -> 27,28,35,36 restored.
REQ-037 cmd 8 then cmd 9 at (4,4) -> window 36 after max; cmd_valid held during EXEC -> second command taken only after busy falls.
REQ-038 Reset low while IRB_A=20 in WRITE -> busy=1, IRB_RW=1, done=0 immediately; after release IROM_A restarts at 0.
